// File: rtl/det_sched_pkg.sv
// Shared definitions for the round-robin detector scheduler.
//   state_t : scheduler FSM states
//   DEF_*   : default N / CW / MAX_LEN
//   idx_w() : index width for a range of n values, never narrower than 1 bit
package det_sched_pkg;

    localparam int unsigned DEF_N       = 4;
    localparam int unsigned DEF_CW      = 8;
    localparam int unsigned DEF_MAX_LEN = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req : request vector
//   ptr : index of the most recently served requester
//   idx : first set req index strictly after ptr, wrapping around
//   any : high when at least one request is set (idx valid)
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        int unsigned c;
        logic [IW-1:0] ci;
        idx = '0;
        any = 1'b0;
        c   = 0;
        ci  = '0;
        // Walk from ptr+1 around to ptr itself; the first hit wins.
        for (int unsigned k = 1; k <= N; k++) begin
            c  = (32'(ptr) + k) % N;
            ci = IW'(c);
            if (!any && req[ci]) begin
                idx = ci;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/det_rr_sched.sv
// Round-robin scheduler sharing one serial Moore sequence detector among N
// serial requesters, one burst at a time.
//   clk, rst         : clock, asynchronous active-low reset
//   req, din, last   : per-channel request, serial data, end-of-burst marker
//   gnt              : one-hot grant, high during STREAM only
//   det_x, det_clr   : serial bit and one-cycle clear toward the detector
//   det_y            : registered detector output
//   hit              : det_y routed to the owning channel
//   cnt_out, cnt_vld : per-burst match count and its one-cycle strobe
//   ch_out           : channel the reported count belongs to
//   tmo              : burst was ended by the MAX_LEN limit
module det_rr_sched
    import det_sched_pkg::*;
#(
    parameter int unsigned  N       = DEF_N,
    parameter int unsigned  CW      = DEF_CW,
    parameter int unsigned  MAX_LEN = DEF_MAX_LEN,
    localparam int unsigned IW      = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  din,
    input  logic [N-1:0]  last,
    output logic [N-1:0]  gnt,
    output logic          det_x,
    output logic          det_clr,
    input  logic          det_y,
    output logic [N-1:0]  hit,
    output logic [CW-1:0] cnt_out,
    output logic          cnt_vld,
    output logic [IW-1:0] ch_out,
    output logic          tmo
);

    localparam int unsigned BW = idx_w(MAX_LEN);

    state_t        state, state_n;
    logic [IW-1:0] sel, sel_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] count, count_n;
    logic [BW-1:0] bitcnt, bitcnt_n;
    logic          tmo_q, tmo_n;

    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sel    <= '0;
            ptr    <= IW'(N - 1);
            count  <= '0;
            bitcnt <= '0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            ptr    <= ptr_n;
            count  <= count_n;
            bitcnt <= bitcnt_n;
            tmo_q  <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        ptr_n    = ptr;
        count_n  = count;
        bitcnt_n = bitcnt;
        tmo_n    = tmo_q;

        gnt      = '0;
        hit      = '0;
        det_x    = 1'b0;
        det_clr  = 1'b0;
        cnt_out  = '0;
        cnt_vld  = 1'b0;
        ch_out   = '0;
        tmo      = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_n   = pick_idx;
                    state_n = CLR;
                end
            end

            CLR: begin
                det_clr  = 1'b1;
                count_n  = '0;
                bitcnt_n = '0;
                tmo_n    = 1'b0;
                state_n  = STREAM;
            end

            STREAM: begin
                gnt[sel] = 1'b1;
                det_x    = din[sel];
                hit[sel] = det_y;
                bitcnt_n = bitcnt + BW'(1);
                if (det_y && (count != '1)) begin
                    count_n = count + CW'(1);
                end
                // last wins over the length limit on the same bit
                if (last[sel]) begin
                    tmo_n   = 1'b0;
                    state_n = DRAIN;
                end else if (bitcnt == BW'(MAX_LEN - 1)) begin
                    tmo_n   = 1'b1;
                    state_n = DRAIN;
                end
            end

            // det_y here reflects the final streamed bit
            DRAIN: begin
                hit[sel] = det_y;
                if (det_y && (count != '1)) begin
                    count_n = count + CW'(1);
                end
                state_n = REPORT;
            end

            REPORT: begin
                cnt_vld = 1'b1;
                cnt_out = count;
                ch_out  = sel;
                tmo     = tmo_q;
                ptr_n   = sel;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_det_rr_sched.sv
// Self-checking bench for det_rr_sched with a behavioural "1010" detector
// attached to the shared detector port.
module tb_det_rr_sched;

    localparam int TN   = 4;
    localparam int TCW  = 2;
    localparam int TMAX = 12;
    localparam int SAT  = (1 << TCW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [TN-1:0]  req, din, last;
    logic [TN-1:0]  gnt, hit;
    logic           det_x, det_clr, det_y;
    logic [TCW-1:0] cnt_out;
    logic           cnt_vld, tmo;
    logic [1:0]     ch_out;

    int total = 0;
    int bad   = 0;
    int last_ch = TN - 1;

    det_rr_sched #(
        .N       (TN),
        .CW      (TCW),
        .MAX_LEN (TMAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .last    (last),
        .gnt     (gnt),
        .det_x   (det_x),
        .det_clr (det_clr),
        .det_y   (det_y),
        .hit     (hit),
        .cnt_out (cnt_out),
        .cnt_vld (cnt_vld),
        .ch_out  (ch_out),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    // Shared detector: Moore "1010" detector, overlapping, sync clear.
    logic [3:0] dhist;
    always @(posedge clk or negedge rst) begin
        if (!rst)         dhist <= 4'b0000;
        else if (det_clr) dhist <= 4'b0000;
        else              dhist <= {dhist[2:0], det_x};
    end
    assign det_y = (dhist == 4'b1010);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    function automatic int rr_next(input logic [TN-1:0] m);
        for (int k = 1; k <= TN; k++) begin
            int c;
            c = (last_ch + k) % TN;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic noise();
        din  = 4'($urandom);
        last = 4'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        noise();
        last_ch = TN - 1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_vld", cnt_vld, 0);
        check("rst_clr", det_clr, 0);
        check("rst_tmo", tmo, 0);
        check("rst_cnt", cnt_out, 0);
        check("rst_hit", hit, 0);
        check("rst_detx", det_x, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One complete burst from the channel the reference arbitration predicts.
    task automatic do_burst(input logic [TN-1:0] mask, input int len,
                            input bit use_last, input logic [63:0] bits);
        int exp_ch, eff, exp_cnt;
        bit exp_tmo;
        logic [TN-1:0] oh;
        exp_ch  = rr_next(mask);
        exp_tmo = !(use_last && len <= TMAX);
        eff     = exp_tmo ? TMAX : len;
        exp_cnt = 0;
        for (int i = 3; i < eff; i++) begin
            if (bits[i-3] && !bits[i-2] && bits[i-1] && !bits[i]) exp_cnt++;
        end
        if (exp_cnt > SAT) exp_cnt = SAT;
        oh = TN'(1) << exp_ch;

        @(negedge clk);                       // IDLE
        req = mask;
        noise();
        @(negedge clk);                       // CLR
        check("clr_pulse", det_clr, 1);
        check("clr_gnt", gnt, 0);
        noise();
        @(negedge clk);                       // first STREAM cycle
        for (int i = 0; i < eff; i++) begin
            if (i > 0) @(negedge clk);
            check("stream_gnt", gnt, oh);
            check("stream_hit", hit, det_y ? oh : '0);
            check("stream_clr", det_clr, 0);
            noise();
            req = 4'($urandom);
            din[exp_ch]  = bits[i];
            last[exp_ch] = use_last && (i == len - 1);
            #1 check("det_x", det_x, bits[i]);
        end
        @(negedge clk);                       // DRAIN
        check("drain_gnt", gnt, 0);
        check("drain_hit", hit, det_y ? oh : '0);
        check("drain_detx", det_x, 0);
        check("drain_vld", cnt_vld, 0);
        noise();
        @(negedge clk);                       // REPORT
        check("rep_vld", cnt_vld, 1);
        check("rep_cnt", cnt_out, exp_cnt);
        check("rep_ch", ch_out, exp_ch);
        check("rep_tmo", tmo, exp_tmo);
        check("rep_gnt", gnt, 0);
        req = '0;
        noise();
        last_ch = exp_ch;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        din = '0;
        last = '0;
        do_reset();

        // single burst on ch1: 1,0,1,0
        do_burst(4'b0010, 4, 1'b1, 64'h5);

        // fairness after a fresh reset
        do_reset();
        for (int b = 0; b < 5; b++) do_burst(4'b1111, 2, 1'b1, 64'h0);

        // count and detector isolation
        do_burst(4'b0100, 9, 1'b1, 64'h0A5);
        do_burst(4'b1000, 2, 1'b1, 64'h1);

        // timeout, then last on the limit bit, then minimum length
        do_burst(4'b0001, TMAX, 1'b0, {$urandom, $urandom});
        do_burst(4'b0001, TMAX, 1'b1, {$urandom, $urandom});
        do_burst(4'b0001, 1, 1'b1, 64'h1);

        // saturation: 1010 x3
        do_burst(4'b0010, TMAX, 1'b1, 64'h555);

        // reset in the middle of a burst on ch2
        @(negedge clk);
        req = 4'b0100;
        repeat (2) @(negedge clk);
        check("mid_gnt_pre", gnt, 4'b0100);
        din[2] = 1'b1;
        last = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_gnt", gnt, 0);
        check("mid_vld", cnt_vld, 0);
        check("mid_hit", hit, 0);
        last_ch = TN - 1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_burst(4'b0110, 3, 1'b1, 64'h5);

        // randomized bursts
        for (int r = 0; r < 40; r++) begin
            logic [63:0] bits;
            bits = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) bits = 64'h5555_5555_5555_5555 ^ (64'h1 << $urandom_range(0, 15));
            do_burst(4'($urandom_range(1, 15)), $urandom_range(1, TMAX + 2),
                     $urandom_range(0, 3) != 0, bits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
